// File: rtl/mmio_uart.sv
`default_nettype none
// ============================================================================
// Module      : mmio_uart
// Description : Memory-mapped UART peripheral. The CPU pushes TX bytes and
//               pops RX bytes through the data register and polls a status
//               register. TX bytes are buffered and sent as 8N1 serial
//               frames. Received 8N1 frames are buffered for CPU reads.
// Ports       : CLK      - system clock, rising edge
//               RST      - synchronous reset, active-high
//               sel_data - data register select
//               sel_stat - status register select
//               write    - bus write qualifier (one cycle per access)
//               rd       - bus read qualifier (one cycle per access)
//               wdata    - write data, [7:0] used
//               rdata    - read data, combinational
//               tx       - serial output, idles high
//               rx       - serial input, asynchronous
//               irq      - high while the RX FIFO holds data
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_uart #(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_AW      = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        sel_data,
    input  logic        sel_stat,
    input  logic        write,
    input  logic        rd,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        tx,
    input  logic        rx,
    output logic        irq
);

    localparam int c_DEPTH = 1 << FIFO_AW;
    localparam int c_CW    = $clog2(CLKS_PER_BIT);

    localparam logic [c_CW-1:0]    c_BIT_END  = c_CW'(CLKS_PER_BIT - 1);
    localparam logic [c_CW-1:0]    c_HALF_END = c_CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [FIFO_AW:0]   c_FULL_CNT = (FIFO_AW + 1)'(c_DEPTH);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_START = 2'd1;
    localparam logic [1:0] c_S_DATA  = 2'd2;
    localparam logic [1:0] c_S_STOP  = 2'd3;

    // ------------------------------------------------------------------
    // Bus decode: selecting both registers at once is a no-op access.
    // ------------------------------------------------------------------
    logic w_sel_ok;
    logic w_push;
    logic w_pop;
    logic w_sread;
    logic w_unused;

    assign w_sel_ok = ~(sel_data & sel_stat);
    assign w_push   = w_sel_ok & sel_data & write;
    assign w_pop    = w_sel_ok & sel_data & rd & ~write;
    assign w_sread  = w_sel_ok & sel_stat & rd & ~write;
    assign w_unused = ^wdata[15:8];

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]         r_tx_mem [c_DEPTH];
    logic [FIFO_AW-1:0] r_tx_wp;
    logic [FIFO_AW-1:0] r_tx_rp;
    logic [FIFO_AW:0]   r_tx_cnt;
    logic               w_tx_full;
    logic               w_tx_empty;
    logic               w_tx_wr;
    logic               w_tx_rd;
    logic [7:0]         w_tx_head;

    assign w_tx_full  = (r_tx_cnt == c_FULL_CNT);
    assign w_tx_empty = (r_tx_cnt == '0);
    assign w_tx_wr    = w_push & ~w_tx_full;
    assign w_tx_head  = r_tx_mem[r_tx_rp];

    always_ff @(posedge CLK) begin
        if (w_tx_wr) begin
            r_tx_mem[r_tx_wp] <= wdata[7:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_tx_wp  <= '0;
            r_tx_rp  <= '0;
            r_tx_cnt <= '0;
        end else begin
            if (w_tx_wr) begin
                r_tx_wp <= r_tx_wp + 1'b1;
            end
            if (w_tx_rd) begin
                r_tx_rp <= r_tx_rp + 1'b1;
            end
            case ({w_tx_wr, w_tx_rd})
                2'b10:   r_tx_cnt <= r_tx_cnt + 1'b1;
                2'b01:   r_tx_cnt <= r_tx_cnt - 1'b1;
                default: r_tx_cnt <= r_tx_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // TX FSM. The FIFO head is popped on the same edge that loads the
    // shift register, either from IDLE or at the end of a STOP bit so
    // frames run back-to-back without an idle gap.
    // ------------------------------------------------------------------
    logic [1:0]      r_tx_state;
    logic [c_CW-1:0] r_tx_tick;
    logic [2:0]      r_tx_bitn;
    logic [7:0]      r_tx_shift;
    logic            r_tx;
    logic            w_tx_bit_end;

    assign w_tx_bit_end = (r_tx_tick == c_BIT_END);
    assign w_tx_rd      = ~w_tx_empty &
                          ((r_tx_state == c_S_IDLE) |
                           ((r_tx_state == c_S_STOP) & w_tx_bit_end));

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_tx_state <= c_S_IDLE;
            r_tx_tick  <= '0;
            r_tx_bitn  <= '0;
            r_tx_shift <= '0;
            r_tx       <= 1'b1;
        end else begin
            case (r_tx_state)
                c_S_IDLE: begin
                    r_tx_tick <= '0;
                    if (!w_tx_empty) begin
                        r_tx_shift <= w_tx_head;
                        r_tx       <= 1'b0;
                        r_tx_state <= c_S_START;
                    end
                end
                c_S_START: begin
                    if (w_tx_bit_end) begin
                        r_tx_tick  <= '0;
                        r_tx_bitn  <= '0;
                        r_tx       <= r_tx_shift[0];
                        r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                        r_tx_state <= c_S_DATA;
                    end else begin
                        r_tx_tick <= r_tx_tick + 1'b1;
                    end
                end
                c_S_DATA: begin
                    if (w_tx_bit_end) begin
                        r_tx_tick <= '0;
                        if (r_tx_bitn == 3'd7) begin
                            r_tx       <= 1'b1;
                            r_tx_state <= c_S_STOP;
                        end else begin
                            r_tx       <= r_tx_shift[0];
                            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                            r_tx_bitn  <= r_tx_bitn + 1'b1;
                        end
                    end else begin
                        r_tx_tick <= r_tx_tick + 1'b1;
                    end
                end
                c_S_STOP: begin
                    if (w_tx_bit_end) begin
                        r_tx_tick <= '0;
                        if (!w_tx_empty) begin
                            r_tx_shift <= w_tx_head;
                            r_tx       <= 1'b0;
                            r_tx_state <= c_S_START;
                        end else begin
                            r_tx_state <= c_S_IDLE;
                        end
                    end else begin
                        r_tx_tick <= r_tx_tick + 1'b1;
                    end
                end
                default: begin
                    r_tx_state <= c_S_IDLE;
                    r_tx       <= 1'b1;
                end
            endcase
        end
    end

    assign tx = r_tx;

    // ------------------------------------------------------------------
    // RX synchroniser; r_rx_prev holds the previous synchronised value
    // for start-edge detection.
    // ------------------------------------------------------------------
    logic r_rx_meta;
    logic r_rx_sync;
    logic r_rx_prev;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // ------------------------------------------------------------------
    // RX FSM
    // ------------------------------------------------------------------
    logic [1:0]      r_rx_state;
    logic [c_CW-1:0] r_rx_tick;
    logic [2:0]      r_rx_bitn;
    logic [7:0]      r_rx_shift;
    logic            w_rx_bit_end;
    logic            w_rx_stop_smp;
    logic            w_rx_push;
    logic            w_rx_ferr;

    assign w_rx_bit_end  = (r_rx_tick == c_BIT_END);
    assign w_rx_stop_smp = (r_rx_state == c_S_STOP) & w_rx_bit_end;
    assign w_rx_push     = w_rx_stop_smp & r_rx_sync;
    assign w_rx_ferr     = w_rx_stop_smp & ~r_rx_sync;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rx_state <= c_S_IDLE;
            r_rx_tick  <= '0;
            r_rx_bitn  <= '0;
            r_rx_shift <= '0;
        end else begin
            case (r_rx_state)
                c_S_IDLE: begin
                    r_rx_tick <= '0;
                    if (r_rx_prev && !r_rx_sync) begin
                        r_rx_state <= c_S_START;
                    end
                end
                c_S_START: begin
                    // Mid-start-bit recheck filters out short glitches.
                    if (r_rx_tick == c_HALF_END) begin
                        r_rx_tick  <= '0;
                        r_rx_bitn  <= '0;
                        r_rx_state <= r_rx_sync ? c_S_IDLE : c_S_DATA;
                    end else begin
                        r_rx_tick <= r_rx_tick + 1'b1;
                    end
                end
                c_S_DATA: begin
                    if (w_rx_bit_end) begin
                        r_rx_tick  <= '0;
                        r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                        if (r_rx_bitn == 3'd7) begin
                            r_rx_state <= c_S_STOP;
                        end else begin
                            r_rx_bitn <= r_rx_bitn + 1'b1;
                        end
                    end else begin
                        r_rx_tick <= r_rx_tick + 1'b1;
                    end
                end
                c_S_STOP: begin
                    if (w_rx_bit_end) begin
                        r_rx_tick  <= '0;
                        r_rx_state <= c_S_IDLE;
                    end else begin
                        r_rx_tick <= r_rx_tick + 1'b1;
                    end
                end
                default: begin
                    r_rx_state <= c_S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO. A CPU pop in the same cycle as a received byte frees the
    // slot, so a full FIFO accepts the byte without overrun.
    // ------------------------------------------------------------------
    logic [7:0]         r_rx_mem [c_DEPTH];
    logic [FIFO_AW-1:0] r_rx_wp;
    logic [FIFO_AW-1:0] r_rx_rp;
    logic [FIFO_AW:0]   r_rx_cnt;
    logic               w_rx_full;
    logic               w_rx_empty;
    logic               w_rx_rd;
    logic               w_rx_wr;
    logic               w_rx_ovr_set;
    logic [7:0]         w_rx_head;

    assign w_rx_full    = (r_rx_cnt == c_FULL_CNT);
    assign w_rx_empty   = (r_rx_cnt == '0);
    assign w_rx_rd      = w_pop & ~w_rx_empty;
    assign w_rx_wr      = w_rx_push & (~w_rx_full | w_rx_rd);
    assign w_rx_ovr_set = w_rx_push & ~w_rx_wr;
    assign w_rx_head    = r_rx_mem[r_rx_rp];

    always_ff @(posedge CLK) begin
        if (w_rx_wr) begin
            r_rx_mem[r_rx_wp] <= r_rx_shift;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rx_wp  <= '0;
            r_rx_rp  <= '0;
            r_rx_cnt <= '0;
        end else begin
            if (w_rx_wr) begin
                r_rx_wp <= r_rx_wp + 1'b1;
            end
            if (w_rx_rd) begin
                r_rx_rp <= r_rx_rp + 1'b1;
            end
            case ({w_rx_wr, w_rx_rd})
                2'b10:   r_rx_cnt <= r_rx_cnt + 1'b1;
                2'b01:   r_rx_cnt <= r_rx_cnt - 1'b1;
                default: r_rx_cnt <= r_rx_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flags: a set event on the same edge as a status read
    // takes priority over the read-clear.
    // ------------------------------------------------------------------
    logic r_ferr;
    logic r_rx_ovr;
    logic r_tx_drop;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ferr    <= 1'b0;
            r_rx_ovr  <= 1'b0;
            r_tx_drop <= 1'b0;
        end else begin
            if (w_rx_ferr) begin
                r_ferr <= 1'b1;
            end else if (w_sread) begin
                r_ferr <= 1'b0;
            end
            if (w_rx_ovr_set) begin
                r_rx_ovr <= 1'b1;
            end else if (w_sread) begin
                r_rx_ovr <= 1'b0;
            end
            if (w_push && w_tx_full) begin
                r_tx_drop <= 1'b1;
            end else if (w_sread) begin
                r_tx_drop <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read mux and interrupt
    // ------------------------------------------------------------------
    logic        w_tx_idle;
    logic [15:0] w_status;

    assign w_tx_idle = w_tx_empty & (r_tx_state == c_S_IDLE);
    assign w_status  = {10'd0, r_tx_drop, r_rx_ovr, r_ferr,
                        w_tx_idle, w_tx_full, ~w_rx_empty};

    always_comb begin
        rdata = 16'h0000;
        if (w_pop) begin
            if (!w_rx_empty) begin
                rdata = {8'h00, w_rx_head};
            end
        end else if (w_sread) begin
            rdata = w_status;
        end
    end

    assign irq = ~w_rx_empty;

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_uart
// Description : Self-checking bench for mmio_uart with CLKS_PER_BIT=4.
//               Bus-decode vectors from a table, TX/RX data through
//               scoreboard queues, hand-written sequences for framing,
//               overrun, drop and glitch corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_uart;

    localparam int CPB = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic        sel_data;
    logic        sel_stat;
    logic        write;
    logic        rd;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        tx;
    logic        rx;
    logic        irq;

    int tests = 0;
    int fails = 0;

    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];

    mmio_uart #(
        .CLKS_PER_BIT(CPB),
        .FIFO_AW     (4)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .sel_data(sel_data),
        .sel_stat(sel_stat),
        .write   (write),
        .rd      (rd),
        .wdata   (wdata),
        .rdata   (rdata),
        .tx      (tx),
        .rx      (rx),
        .irq     (irq)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        sd;
        logic        ss;
        logic        w;
        logic        r;
        logic [15:0] wd;
        logic [15:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, got, exp);
        end
    endtask

    // One bus cycle: drive at a falling edge, sample rdata, hold across the
    // rising edge, release at the next falling edge.
    task automatic bus(input logic sd, input logic ss, input logic w, input logic r,
                       input logic [15:0] wd, output logic [15:0] got);
        sel_data = sd;
        sel_stat = ss;
        write    = w;
        rd       = r;
        wdata    = wd;
        #1 got = rdata;
        @(negedge CLK);
        sel_data = 1'b0;
        sel_stat = 1'b0;
        write    = 1'b0;
        rd       = 1'b0;
        wdata    = 16'h0000;
    endtask

    task automatic push(input logic [7:0] b, input bit accepted);
        logic [15:0] got;
        bus(1'b1, 1'b0, 1'b1, 1'b0, {8'h00, b}, got);
        if (accepted) tx_q.push_back(b);
    endtask

    task automatic sread(input string name, input logic [15:0] exp);
        logic [15:0] got;
        bus(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, got);
        check(name, got, exp);
    endtask

    task automatic pop(input string name);
        logic [15:0] got;
        logic [15:0] exp;
        bus(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, got);
        exp = (rx_q.size() != 0) ? {8'h00, rx_q.pop_front()} : 16'h0000;
        check(name, got, exp);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int tail);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            repeat (CPB) @(negedge CLK);
        end
        rx = 1'b1;
        repeat (tail) @(negedge CLK);
    endtask

    // Serial TX monitor: decodes each frame mid-bit and compares with the
    // scoreboard queue filled by push().
    initial begin : tx_mon
        logic [7:0] d;
        forever begin
            @(negedge CLK);
            if (RST === 1'b0 && tx === 1'b0) begin
                repeat (CPB / 2) @(negedge CLK);
                check("tx_start_bit", {15'd0, tx}, 16'h0000);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge CLK);
                    d[i] = tx;
                end
                repeat (CPB) @(negedge CLK);
                check("tx_stop_bit", {15'd0, tx}, 16'h0001);
                if (tx_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL tx_unexpected: got 0x%02h expected no frame", d);
                end else begin
                    check("tx_byte", {8'h00, d}, {8'h00, tx_q.pop_front()});
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        vec_t vecs [9];
        int   c;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000}; // idle bus
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0004}; // status after reset
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000}; // pop empty
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000}; // both selects read
        vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0055, 16'h0000}; // both selects write
        vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0004}; // no push happened
        vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000}; // read with write
        vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000}; // select without rd
        vecs[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0004}; // still idle

        RST      = 1'b1;
        sel_data = 1'b0;
        sel_stat = 1'b0;
        write    = 1'b0;
        rd       = 1'b0;
        wdata    = 16'h0000;
        rx       = 1'b1;
        repeat (3) @(negedge CLK);
        check("reset_tx", {15'd0, tx}, 16'h0001);
        check("reset_irq", {15'd0, irq}, 16'h0000);
        RST = 1'b0;
        @(negedge CLK);

        for (int i = 0; i < 9; i++) begin
            logic [15:0] got;
            bus(vecs[i].sd, vecs[i].ss, vecs[i].w, vecs[i].r, vecs[i].wd, got);
            check($sformatf("vec%0d", i), got, vecs[i].exp);
        end
        check("vec_irq", {15'd0, irq}, 16'h0000);

        // Single TX frame: latency and end-of-frame idle boundary.
        push(8'hA5, 1'b1);
        check("tx_high_after_push", {15'd0, tx}, 16'h0001);
        @(negedge CLK);
        check("tx_low_next_cycle", {15'd0, tx}, 16'h0000);
        repeat (39) @(negedge CLK);
        sread("tx_busy_last_cycle", 16'h0000);
        sread("tx_idle_after_frame", 16'h0004);

        // TX FIFO fill: 17 accepted (one drained into the FSM), 18th dropped.
        for (int i = 0; i < 17; i++) push(8'h11 + 8'(i), 1'b1);
        push(8'h22, 1'b0);
        sread("tx_drop_set", 16'h0022);
        sread("tx_drop_clear", 16'h0002);
        c = 0;
        while (tx_q.size() != 0 && c < 1200) begin
            @(negedge CLK);
            c++;
        end
        check("tx_drain", 16'(tx_q.size()), 16'h0000);
        repeat (5) @(negedge CLK);
        sread("tx_idle_after_drain", 16'h0004);

        // Good RX frame.
        send_frame(8'h3C, 1'b1, 3);
        rx_q.push_back(8'h3C);
        check("rx_irq_set", {15'd0, irq}, 16'h0001);
        pop("rx_pop_3c");
        check("rx_irq_clear", {15'd0, irq}, 16'h0000);
        pop("rx_pop_empty");

        // Framing error.
        send_frame(8'h5A, 1'b0, 3);
        check("ferr_irq", {15'd0, irq}, 16'h0000);
        sread("ferr_set", 16'h000C);
        sread("ferr_clear", 16'h0004);

        // One-cycle glitch on rx.
        rx = 1'b0;
        @(negedge CLK);
        rx = 1'b1;
        repeat (10) @(negedge CLK);
        sread("glitch_status", 16'h0004);
        check("glitch_irq", {15'd0, irq}, 16'h0000);

        // RX overrun and pop on the stop-sample cycle of a full FIFO.
        for (int i = 0; i < 16; i++) begin
            send_frame(8'h80 + 8'(i), 1'b1, 3);
            rx_q.push_back(8'h80 + 8'(i));
        end
        sread("rx_full_status", 16'h0005);
        send_frame(8'hEE, 1'b1, 3);
        sread("rx_ovr_set", 16'h0015);
        sread("rx_ovr_clear", 16'h0005);
        send_frame(8'h77, 1'b1, 0);
        pop("rx_pop_at_stop");
        rx_q.push_back(8'h77);
        repeat (3) @(negedge CLK);
        sread("rx_no_ovr", 16'h0005);
        for (int i = 0; i < 16; i++) pop($sformatf("rx_pop_%0d", i));
        sread("rx_drained", 16'h0004);
        pop("rx_pop_after_drain");

        check("tx_q_empty", 16'(tx_q.size()), 16'h0000);
        check("rx_q_empty", 16'(rx_q.size()), 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
